mem_stage_lsu: RTL and testbench

- Load/store unit for the MEM stage of the 5-stage RV32I pipeline.
- Consumes the EX/MEM request (address, store data, funct3, read/write) and runs a valid/ack transaction on the data bus.
- Handles byte-enable and lane alignment for stores, and sign/zero extension for loads.
- Asserts busy to stall the pipeline until the access completes. Flags misaligned/unsupported accesses and bus timeouts.

---
 rtl/mem_stage_lsu_if.sv | 14 +
 rtl/mem_stage_lsu.sv | 164 ++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_lsu_if.sv
// Data-bus port bundle between the MEM-stage load/store unit and the data memory.
// The LSU side uses the master modport; memory models use the slave modport.
interface mem_stage_lsu_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, we, addr, be, wdata, input ack, rdata);
  modport slave  (input req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: runs one valid/ack bus transaction per request, aligns
// store lanes and extends load data, and stalls the pipeline until the access completes.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | waiting for req_valid; latches the request and checks legality
// S_BUS  | bus_req held until bus_ack or until the timeout counter expires
// S_RESP | one-cycle completion pulse; pipeline advances on this edge
module mem_stage_lsu #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        misalign,
  output logic        bus_err,
  mem_stage_lsu_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [7:0]  cnt_q;
  logic [31:0] rdata_q;
  logic        mis_q;
  logic        err_q;
  logic        in_bus;
  logic        legal_in;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_ext;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;

  // Stores only have sb/sh/sw; the unsigned load codes are illegal for stores.
  function automatic logic is_legal(logic we, logic [2:0] f3, logic [1:0] a);
    case (f3)
      3'b000:  is_legal = 1'b1;
      3'b001:  is_legal = ~a[0];
      3'b010:  is_legal = (a == 2'b00);
      3'b100:  is_legal = ~we;
      3'b101:  is_legal = ~we & ~a[0];
      default: is_legal = 1'b0;
    endcase
  endfunction

  assign legal_in = is_legal(req_we, req_funct3, req_addr[1:0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    rsp_valid = 1'b0;
    in_bus    = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = req_valid;
        if (req_valid) state_d = legal_in ? S_BUS : S_RESP;
      end
      S_BUS: begin
        busy   = 1'b1;
        in_bus = 1'b1;
        if (bus.ack || cnt_q == TO_LAST) state_d = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    lane_b = 8'(bus.rdata >> {addr_q[1:0], 3'b000});
    lane_h = addr_q[1] ? bus.rdata[31:16] : bus.rdata[15:0];
    case (f3_q)
      3'b000:  load_ext = {{24{lane_b[7]}}, lane_b};
      3'b001:  load_ext = {{16{lane_h[15]}}, lane_h};
      3'b100:  load_ext = {24'h0, lane_b};
      3'b101:  load_ext = {16'h0, lane_h};
      default: load_ext = bus.rdata;
    endcase
  end

  always_comb begin
    case (f3_q[1:0])
      2'b00: begin
        st_be    = 4'b0001 << addr_q[1:0];
        st_wdata = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        st_be    = 4'b0011 << addr_q[1:0];
        st_wdata = {2{wdata_q[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = wdata_q;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      cnt_q   <= 8'h0;
      rdata_q <= 32'h0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            cnt_q   <= 8'h0;
            rdata_q <= 32'h0;
            mis_q   <= ~legal_in;
            err_q   <= 1'b0;
          end
        end
        S_BUS: begin
          cnt_q <= cnt_q + 8'd1;
          // An ack in the final allowed cycle still wins over the timeout.
          if (bus.ack)                rdata_q <= we_q ? 32'h0 : load_ext;
          else if (cnt_q == TO_LAST)  err_q   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.req   = in_bus;
  assign bus.we    = in_bus & we_q;
  assign bus.addr  = in_bus ? {addr_q[31:2], 2'b00} : 32'h0;
  assign bus.be    = in_bus ? (we_q ? st_be : 4'b1111) : 4'b0000;
  assign bus.wdata = (in_bus && we_q) ? st_wdata : 32'h0;

  assign rsp_rdata = rsp_valid ? rdata_q : 32'h0;
  assign misalign  = rsp_valid & mis_q;
  assign bus_err   = rsp_valid & err_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: a vector table of requests with a bus responder,
// a response scoreboard, and hand sequences for late ack, back-to-back and mid-bus reset.
module tb_mem_stage_lsu;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        busy;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        misalign;
  logic        bus_err;

  mem_stage_lsu_if bus_if ();

  mem_stage_lsu #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .busy       (busy),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .misalign   (misalign),
    .bus_err    (bus_err),
    .bus        (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ack_wait;   // bus_req cycles before ack; -1 = never ack
    int          exp_req;    // expected number of bus_req cycles
    int          exp_busy;
    logic [3:0]  exp_be;
    logic [31:0] exp_bwdata;
    logic [31:0] exp_rdata;
    logic        exp_mis;
    logic        exp_err;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        mis;
    logic        err;
  } exp_t;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  vec_t tbl[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(string name, logic we, logic [2:0] f3, logic [31:0] addr,
                              logic [31:0] wdata, logic [31:0] rdata, int ack_wait,
                              logic [3:0] be, logic [31:0] bwdata, logic [31:0] exp_rdata,
                              logic mis, logic err);
    vec_t v;
    v.name = name; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.ack_wait = ack_wait; v.exp_be = be; v.exp_bwdata = bwdata; v.exp_rdata = exp_rdata;
    v.exp_mis = mis; v.exp_err = err;
    if (mis)              v.exp_req = 0;
    else if (ack_wait < 0) v.exp_req = TO;
    else                  v.exp_req = ack_wait + 1;
    v.exp_busy = 1 + v.exp_req;
    return v;
  endfunction

  // Scoreboard: every completion pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_rdata"}, rsp_rdata, e.rdata);
        check({e.name, "_flags"}, {30'h0, misalign, bus_err}, {30'h0, e.mis, e.err});
      end
    end
  end

  // Entered just after a posedge; returns just after the posedge that ends RESP,
  // leaving req_valid asserted so the caller decides between back-to-back or idle.
  task automatic apply(vec_t v);
    int   busy_n = 0;
    int   req_n = 0;
    logic done = 1'b0;
    logic bus_ok = 1'b1;
    exp_t e;
    req_valid  = 1'b1;
    req_we     = v.we;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    e.name = v.name; e.rdata = v.exp_rdata; e.mis = v.exp_mis; e.err = v.exp_err;
    sb.push_back(e);
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (bus_if.req) begin
        if (bus_if.we !== v.we || bus_if.addr !== {v.addr[31:2], 2'b00} ||
            bus_if.be !== v.exp_be || (v.we && bus_if.wdata !== v.exp_bwdata))
          bus_ok = 1'b0;
        bus_if.ack   = (req_n == v.ack_wait);
        bus_if.rdata = (req_n == v.ack_wait) ? v.rdata : 32'h5A5A_5A5A;
        req_n++;
      end else begin
        bus_if.ack = 1'b0;
      end
      if (busy) busy_n++;
      if (rsp_valid) done = 1'b1;
    end
    @(posedge clk); #1;
    bus_if.ack = 1'b0;
    check({v.name, "_resp_seen"}, {31'h0, done}, 32'd1);
    check({v.name, "_busy_cycles"}, busy_n, v.exp_busy);
    check({v.name, "_req_cycles"}, req_n, v.exp_req);
    if (v.exp_req > 0) check({v.name, "_bus_outputs"}, {31'h0, bus_ok}, 32'd1);
  endtask

  task automatic idle(int n);
    req_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cnt;
    vec_t v;
    tbl.push_back(mk("lb",      0, 3'b000, 32'h103, 32'h0,       32'h80FF_0000, 0, 4'hF, 32'h0,       32'hFFFF_FF80, 0, 0));
    tbl.push_back(mk("lbu",     0, 3'b100, 32'h103, 32'h0,       32'h80FF_0000, 0, 4'hF, 32'h0,       32'h0000_0080, 0, 0));
    tbl.push_back(mk("sh",      1, 3'b001, 32'h102, 32'h1234_ABCD, 32'h0,       0, 4'hC, 32'hABCD_ABCD, 32'h0,      0, 0));
    tbl.push_back(mk("lw_mis",  0, 3'b010, 32'h101, 32'h0,       32'h0,         0, 4'hF, 32'h0,       32'h0,         1, 0));
    tbl.push_back(mk("sw_f011", 1, 3'b011, 32'h100, 32'h0,       32'h0,         0, 4'hF, 32'h0,       32'h0,         1, 0));
    tbl.push_back(mk("lw_wait", 0, 3'b010, 32'h200, 32'h0,       32'hDEAD_BEEF, 3, 4'hF, 32'h0,       32'hDEAD_BEEF, 0, 0));
    tbl.push_back(mk("lw_to",   0, 3'b010, 32'h204, 32'h0,       32'hDEAD_BEEF, -1, 4'hF, 32'h0,      32'h0,         0, 1));
    tbl.push_back(mk("sb",      1, 3'b000, 32'h001, 32'h0000_00A7, 32'h0,       1, 4'h2, 32'hA7A7_A7A7, 32'h0,      0, 0));
    tbl.push_back(mk("lh_hi",   0, 3'b001, 32'h202, 32'h0,       32'h8001_1234, 0, 4'hF, 32'h0,       32'hFFFF_8001, 0, 0));
    tbl.push_back(mk("lhu_hi",  0, 3'b101, 32'h202, 32'h0,       32'h8001_1234, 0, 4'hF, 32'h0,       32'h0000_8001, 0, 0));
    tbl.push_back(mk("lh_lo",   0, 3'b001, 32'h000, 32'h0,       32'h1234_F00D, 0, 4'hF, 32'h0,       32'hFFFF_F00D, 0, 0));
    tbl.push_back(mk("lb_b1",   0, 3'b000, 32'h001, 32'h0,       32'h0000_7F00, 0, 4'hF, 32'h0,       32'h0000_007F, 0, 0));
    tbl.push_back(mk("lbu_b2",  0, 3'b100, 32'h002, 32'h0,       32'h00C3_0000, 2, 4'hF, 32'h0,       32'h0000_00C3, 0, 0));
    tbl.push_back(mk("lh_mis",  0, 3'b001, 32'h003, 32'h0,       32'h0,         0, 4'hF, 32'h0,       32'h0,         1, 0));
    tbl.push_back(mk("ld_f110", 0, 3'b110, 32'h000, 32'h0,       32'h0,         0, 4'hF, 32'h0,       32'h0,         1, 0));
    tbl.push_back(mk("st_f100", 1, 3'b100, 32'h000, 32'h0,       32'h0,         0, 4'hF, 32'h0,       32'h0,         1, 0));
    tbl.push_back(mk("sw",      1, 3'b010, 32'h010, 32'hCAFE_F00D, 32'h0,       2, 4'hF, 32'hCAFE_F00D, 32'h0,      0, 0));

    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; bus_if.ack = 1'b0; bus_if.rdata = 32'h0;
    #12;
    check("rst_busy",  {31'h0, busy}, 32'd0);
    check("rst_rsp",   {29'h0, rsp_valid, misalign, bus_err}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'h0);
    check("rst_bus",   {27'h0, bus_if.req, bus_if.be}, 32'd0);
    check("rst_addr",  bus_if.addr, 32'h0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      apply(tbl[i]);
      idle(1);
      if (tbl[i].name == "lw_to") begin
        // A late ack with nothing outstanding must not start or complete anything.
        cnt = 0;
        bus_if.ack = 1'b1; bus_if.rdata = 32'h1111_2222;
        repeat (3) begin
          @(negedge clk);
          if (bus_if.req || busy || rsp_valid) cnt++;
        end
        bus_if.ack = 1'b0;
        @(posedge clk); #1;
        check("late_ack_ignored", cnt, 0);
      end
    end

    // Back-to-back: second request presented in the IDLE cycle right after RESP.
    apply(mk("b2b_a", 0, 3'b010, 32'h300, 32'h0, 32'h0BAD_F00D, 0, 4'hF, 32'h0, 32'h0BAD_F00D, 0, 0));
    apply(mk("b2b_b", 1, 3'b000, 32'h302, 32'h0000_0055, 32'h0, 1, 4'h4, 32'h5555_5555, 32'h0, 0, 0));
    apply(mk("b2b_c", 0, 3'b010, 32'h303, 32'h0, 32'h0, 0, 4'hF, 32'h0, 32'h0, 1, 0));
    idle(1);

    // Reset in the second BUS cycle: bus_req and busy drop at once, no response follows.
    bus_if.ack = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h400;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_bus_req", {31'h0, bus_if.req}, 32'd1);
    #2;
    reset = 1'b1; req_valid = 1'b0;
    #1;
    check("rst_mid_bus_req", {31'h0, bus_if.req}, 32'd0);
    check("rst_mid_busy", {31'h0, busy}, 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid || bus_if.req) cnt++;
    end
    check("no_rsp_after_rst", cnt, 0);
    @(posedge clk); #1;
    v = mk("lw_after_rst", 0, 3'b010, 32'h404, 32'h0, 32'h7654_3210, 1, 4'hF, 32'h0, 32'h7654_3210, 0, 0);
    apply(v);
    idle(2);

    check("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
